// File: rtl/fixed_to_decimal_if.sv
// Handshake and digit bus between the arithmetic core (master) and the Q8.8-to-decimal converter (slave).
interface fixed_to_decimal_if;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [3:0]  int_hund;
  logic [3:0]  int_tens;
  logic [3:0]  int_ones;
  logic [3:0]  frac_d1;
  logic [3:0]  frac_d2;

  modport master (
    output start, bin_in,
    input  busy, done, int_hund, int_tens, int_ones, frac_d1, frac_d2
  );

  modport slave (
    input  start, bin_in,
    output busy, done, int_hund, int_tens, int_ones, frac_d1, frac_d2
  );
endinterface

// File: rtl/fixed_to_decimal.sv
// Sequential Q8.8 -> BCD converter: double-dabble on the integer byte, multiply-by-10 on the fraction.
// Optional FTD_ROUND_EN: adds a thousandths digit and a RND state that rounds hundredths half-up.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// INT    | 8 double-dabble steps on the integer byte
// FRAC   | one fraction digit per cycle (2, or 3 with rounding)
// RND    | decimal round-up with carry ripple (FTD_ROUND_EN only)
// DONE   | final digits are registered into the outputs, done pulses next cycle
module fixed_to_decimal (
  input  logic                      clk,
  input  logic                      rst_n,
  fixed_to_decimal_if.slave         bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INT  = 3'd1,
    S_FRAC = 3'd2,
    S_RND  = 3'd3,
    S_DONE = 3'd4
  } state_e;

`ifdef FTD_ROUND_EN
  localparam logic [2:0] FRAC_LAST = 3'd2;
`else
  localparam logic [2:0] FRAC_LAST = 3'd1;
`endif

  state_e      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [7:0]  int_q;
  logic [11:0] bcd_q;
  logic [7:0]  frac_q;
  logic [3:0]  d1_q, d2_q;
`ifdef FTD_ROUND_EN
  logic [3:0]  d3_q;
`endif
  logic [3:0]  hund_q, tens_q, ones_q, f1_q, f2_q;
  logic        done_q;

  logic [11:0] bcd_shift;
  logic [11:0] prod;

  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Partial value never exceeds 255, so the hundreds nibble stays below 5 and needs no adjust.
  assign bcd_shift = {bcd_q[10:8], dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0]), int_q[7]};
  assign prod      = {4'd0, frac_q} * 12'd10;

`ifdef FTD_ROUND_EN
  logic [3:0] rnd_dig [5];

  always_comb begin : round_ripple
    logic carry;
    rnd_dig[0] = d2_q;
    rnd_dig[1] = d1_q;
    rnd_dig[2] = bcd_q[3:0];
    rnd_dig[3] = bcd_q[7:4];
    rnd_dig[4] = bcd_q[11:8];
    carry = (d3_q >= 4'd5);
    for (int i = 0; i < 5; i++) begin
      if (carry) begin
        if (rnd_dig[i] == 4'd9) begin
          rnd_dig[i] = 4'd0;
        end else begin
          rnd_dig[i] = rnd_dig[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_INT;
      S_INT:  if (cnt_q == 3'd7) state_d = S_FRAC;
      S_FRAC: if (cnt_q == FRAC_LAST) begin
`ifdef FTD_ROUND_EN
        state_d = S_RND;
`else
        state_d = S_DONE;
`endif
      end
      S_RND:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q != S_IDLE);
    bus.done     = done_q;
    bus.int_hund = hund_q;
    bus.int_tens = tens_q;
    bus.int_ones = ones_q;
    bus.frac_d1  = f1_q;
    bus.frac_d2  = f2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= 3'd0;
      int_q  <= 8'd0;
      bcd_q  <= 12'd0;
      frac_q <= 8'd0;
      d1_q   <= 4'd0;
      d2_q   <= 4'd0;
`ifdef FTD_ROUND_EN
      d3_q   <= 4'd0;
`endif
      hund_q <= 4'd0;
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      f1_q   <= 4'd0;
      f2_q   <= 4'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          int_q  <= bus.bin_in[15:8];
          frac_q <= bus.bin_in[7:0];
          bcd_q  <= 12'd0;
          cnt_q  <= 3'd0;
        end
        S_INT: begin
          bcd_q <= bcd_shift;
          int_q <= {int_q[6:0], 1'b0};
          cnt_q <= cnt_q + 3'd1;
        end
        S_FRAC: begin
          frac_q <= prod[7:0];
          cnt_q  <= cnt_q + 3'd1;
          case (cnt_q)
            3'd0:    d1_q <= prod[11:8];
            3'd1:    d2_q <= prod[11:8];
`ifdef FTD_ROUND_EN
            3'd2:    d3_q <= prod[11:8];
`endif
            default: ;
          endcase
        end
`ifdef FTD_ROUND_EN
        S_RND: begin
          d2_q  <= rnd_dig[0];
          d1_q  <= rnd_dig[1];
          bcd_q <= {rnd_dig[4], rnd_dig[3], rnd_dig[2]};
        end
`endif
        S_DONE: begin
          hund_q <= bcd_q[11:8];
          tens_q <= bcd_q[7:4];
          ones_q <= bcd_q[3:0];
          f1_q   <= d1_q;
          f2_q   <= d2_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
